// File: rtl/mips_regfile_v2.sv
// mips_regfile_v2
//   Clocked MIPS register file: 2^ADDR_W x DATA_W registers, register 0
//   hardwired to zero, NUM_RD registered read ports (legal 1..4), one
//   synchronous write port, and a dump engine that streams every register
//   out one word per cycle.
//
//   Ports
//     clk, rst          rising-edge clock, asynchronous active-high reset
//     rd_addr/rd_data   packed read ports, port i at [i*W +: W]; 1-cycle latency
//     wr_en/wr_addr/wr_data  write port; writes to address 0 are dropped
//     dump_start        starts a dump when the engine is idle
//     dump_busy         engine in RUN
//     dump_valid/dump_addr/dump_data  one dumped word per cycle
//     dump_done         one-cycle pulse after the last word
//
//   Configuration macro: REGFILE_BYPASS_EN
//     defined   - a read or dump of the address being written this edge
//                 captures wr_data (write-first)
//     undefined - the same case captures the old stored value (read-first)
//
//   Dump FSM
//     state | meaning
//     IDLE  | waiting for dump_start
//     RUN   | presenting reg[counter], counter advancing 0..2^ADDR_W-1
//     DONE  | one-cycle dump_done pulse, then back to IDLE

module mips_regfile_v2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     dump_start,
  output logic                     dump_busy,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic                     dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]        dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]        dump_data_q, dump_data_d;
  logic                     dump_done_q, dump_done_d;

  logic wr_active;
  assign wr_active = wr_en && (wr_addr != '0);

  // Value captured by a read-like access of addr given its stored value.
  // Address 0 is forced to zero even though regs_q[0] never changes, so a
  // bypass can never leak wr_data onto register 0.
  function automatic logic [DATA_W-1:0] read_word(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wa,
    input logic [ADDR_W-1:0] wa_addr,
    input logic [DATA_W-1:0] wa_data
  );
    logic [DATA_W-1:0] val;
    val = stored;
`ifdef REGFILE_BYPASS_EN
    if (wa && (wa_addr == addr)) val = wa_data;
`else
    if (wa && (wa_addr == addr)) val = stored;
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_active) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_d[i*DATA_W +: DATA_W] =
        read_word(rd_addr[i*ADDR_W +: ADDR_W], regs_q[rd_addr[i*ADDR_W +: ADDR_W]],
                  wr_active, wr_addr, wr_data);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dump_valid_d = 1'b0;
    dump_done_d  = 1'b0;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        dump_valid_d = 1'b1;
        dump_addr_d  = cnt_q;
        dump_data_d  = read_word(cnt_q, regs_q[cnt_q], wr_active, wr_addr, wr_data);
        cnt_d        = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = DONE;
      end
      DONE: begin
        dump_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      rd_data_q    <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      rd_data_q    <= rd_data_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign dump_busy  = (state_q == RUN);
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_mips_regfile_v2.sv
// Testbench for mips_regfile_v2 (default parameters). Inputs change 1 ns
// after the rising edge; outputs are checked at the same point.
module tb_mips_regfile_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        dump_start = 1'b0;
  logic        dump_busy, dump_valid, dump_done;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  int total = 0;
  int bad   = 0;

  mips_regfile_v2 #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_data", rd_data, 64'h0);
    chk("async_rst_dump_valid", dump_valid, 1'b0);
    chk("async_rst_dump_busy", dump_busy, 1'b0);
    #2 rst = 1'b0;
  endtask

  initial begin
    int nv, ndone, c, found;

    vecs[0] = '{1'b1, 5'd3,  32'h11,         5'd0,  5'd0,  32'h0,         32'h0};
    vecs[1] = '{1'b1, 5'd7,  32'h22,         5'd3,  5'd5,  32'h11,        32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF,   5'd3,  5'd7,  32'h11,        32'h22};
    vecs[3] = '{1'b0, 5'd0,  32'h0,          5'd0,  5'd0,  32'h0,         32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D,   5'd7,  5'd3,  32'h22,        32'h11};
    vecs[5] = '{1'b0, 5'd0,  32'h0,          5'd31, 5'd1,  32'hCAFEF00D,  32'h0};
    vecs[6] = '{1'b1, 5'd3,  32'h33,         5'd31, 5'd31, 32'hCAFEF00D,  32'hCAFEF00D};
    vecs[7] = '{1'b0, 5'd0,  32'h0,          5'd3,  5'd0,  32'h33,        32'h0};

    #12 rst = 1'b0;
    #1;
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_dump_valid", dump_valid, 1'b0);
    chk("reset_dump_busy", dump_busy, 1'b0);
    chk("reset_dump_done", dump_done, 1'b0);
    chk("reset_dump_addr", dump_addr, 5'd0);
    chk("reset_dump_data", dump_data, 32'h0);
    step();

    // Async reset clears stored data
    wr(5'd5, 32'hDEADBEEF);
    rd_addr = {5'd5, 5'd5};
    step();
    chk("pre_reset_reg5", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
    pulse_reset();
    step();
    chk("post_reset_reg5", rd_data, 64'h0);

    // Table-driven read/write vectors
    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      step();
      chk($sformatf("vec%0d_port0", i), rd_data[31:0],  vecs[i].e0);
      chk($sformatf("vec%0d_port1", i), rd_data[63:32], vecs[i].e1);
    end
    wr_en = 1'b0;

    // Same-cycle write/read hazard
    wr(5'd9, 32'hA);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hB;
    rd_addr = {5'd0, 5'd9};
    step();
    wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    chk("hazard_same_edge", rd_data[31:0], 32'hB);
`else
    chk("hazard_same_edge", rd_data[31:0], 32'hA);
`endif
    chk("hazard_port1_zero", rd_data[63:32], 32'h0);
    step();
    chk("hazard_next_cycle", rd_data[31:0], 32'hB);

    // Full dump of reg[k] = k*3
    for (int k = 1; k < 32; k++) wr(5'(k), 32'(k * 3));
    rd_addr = '0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    chk("dump_busy_after_start", dump_busy, 1'b1);
    nv = 0; ndone = 0;
    for (c = 1; c <= 40; c++) begin
      dump_start = (c == 5 || c == 32) ? 1'b1 : 1'b0;
      step();
      if (dump_valid) begin
        chk("dump_addr_seq", {dump_addr, 27'd0}, {5'(c - 1), 27'd0});
        chk("dump_data", dump_data, 32'(nv * 3));
        nv++;
      end
      if (dump_done) begin
        ndone++;
        chk("dump_done_cycle", c, 33);
        chk("dump_valid_at_done", dump_valid, 1'b0);
      end
    end
    dump_start = 1'b0;
    chk("dump_valid_count", nv, 32);
    chk("dump_done_count", ndone, 1);
    chk("dump_idle_after", dump_busy, 1'b0);

    // Reset mid-dump
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    found = 0;
    for (c = 0; c < 40 && found == 0; c++) begin
      step();
      if (dump_valid && dump_addr == 5'd10) found = 1;
    end
    chk("mid_dump_reached_addr10", found, 1);
    pulse_reset();
    ndone = 0; nv = 0;
    for (c = 0; c < 40; c++) begin
      step();
      if (dump_done) ndone++;
      if (dump_valid) nv++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_no_valid", nv, 0);

    // Fresh dump after abort: all registers now zero
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    nv = 0; ndone = 0;
    for (c = 1; c <= 36; c++) begin
      step();
      if (c == 1) chk("fresh_first_valid", {dump_valid, dump_addr}, {1'b1, 5'd0});
      if (dump_valid && dump_data != 32'h0) chk("fresh_dump_zero", dump_data, 32'h0);
      if (dump_valid) nv++;
      if (dump_done) ndone++;
    end
    chk("fresh_valid_count", nv, 32);
    chk("fresh_done_count", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_regfile_v2.md
# mips_regfile_v2

Parametrised, clocked successor to the single-cycle MIPS register file. It provides 2^ADDR_W registers of DATA_W bits with register 0 hardwired to zero, NUM_RD registered read ports and one synchronous write port. A hardware dump engine streams the full register contents out one word per cycle, replacing simulation-only file dumps. The block sits between decode (read ports) and write-back (write port) of the pipelined datapath.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports; legal range 1..4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W]
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- dump_start  in  1  request a full register dump; sampled in IDLE only
- dump_busy  out  1  high while the dump engine is in RUN
- dump_valid  out  1  dump_addr/dump_data valid this cycle
- dump_addr  out  ADDR_W  register index being dumped
- dump_data  out  DATA_W  register contents for dump_addr
- dump_done  out  1  one-cycle pulse after the last word

## Operation
- Reset: all registers, rd_data, dump_addr, dump_data cleared to 0; dump_busy, dump_valid, dump_done = 0; FSM to IDLE. Asserting rst mid-dump aborts it; no dump_done is issued.
- Write: at rising edge, if wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are discarded.
- Read: at each rising edge, rd_data port i <= reg[rd_addr_i]; address 0 always yields 0. No read enable; ports update every cycle.
- Dump FSM, states IDLE, RUN, DONE:
  - IDLE: dump_start=1 -> RUN, counter = 0.
  - RUN: each cycle presents dump_valid=1, dump_addr=counter, dump_data=reg[counter] (sampled like an extra read port addressed by counter); counter increments. After address 2^ADDR_W-1 is presented -> DONE.
  - DONE: dump_done=1 for exactly one cycle, dump_valid=0 -> IDLE.
  - dump_start while in RUN or DONE is ignored. Counter wraps exactly at 2^ADDR_W; no address is repeated or skipped.
- Writes and reads remain fully functional during a dump.

## Timing
- Read latency: 1 cycle from rd_addr to rd_data.
- Write latency: value visible at a read port address applied the cycle after the write edge (1 cycle later on rd_data), or in the same edge when bypass is compiled in.
- Dump: dump_start sampled at edge N; address 0 presented in cycle after edge N+1; last address after edge N+2^ADDR_W; dump_done in the following cycle. Total dump length: 2^ADDR_W + 1 cycles from start acceptance to done.
- Simultaneous write and read or dump of the same nonzero address: governed by the configuration macro below.

## Configuration
- REGFILE_BYPASS_EN defined: a read port or the dump engine addressing wr_addr while wr_en=1 and wr_addr!=0 captures wr_data (write-first).
- REGFILE_BYPASS_EN undefined: same case captures the old stored value (read-first); the new value appears on the next access.

## Test plan
- Reset: write reg[5]=0xDEADBEEF, assert rst asynchronously between edges -> rd_data and reg[5] read 0 immediately after reset releases.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; read address 0 on all ports -> 0.
- Multi-port read: reg[3]=0x11, reg[7]=0x22; rd_addr0=3, rd_addr1=7 -> next cycle rd_data0=0x11, rd_data1=0x22.
- Same-cycle hazard: reg[9]=0xA, then write 0xB to 9 while reading 9 -> rd_data=0xB with REGFILE_BYPASS_EN, 0xA without.
- Full dump: load reg[k]=k*3 for k=1..31, pulse dump_start -> 32 consecutive dump_valid cycles, addr 0..31, data 0,3,...,93, then single dump_done; second dump_start mid-dump is ignored.
- Reset mid-dump: assert rst at address 10 -> dump_valid, dump_busy drop to 0, no dump_done, FSM accepts a fresh dump_start afterwards.
